// File: rtl/seg7_pkg.sv
// Shared seg7 definitions: letter patterns, letter codes and reader FSM states.
// Patterns use bit order {g,f,e,d,c,b,a}, where 1 means the segment is lit.
package seg7_pkg;

  localparam logic [6:0] PAT_BLANK = 7'b0000000;
  localparam logic [6:0] PAT_A     = 7'b1110111;
  localparam logic [6:0] PAT_B     = 7'b1111100;
  localparam logic [6:0] PAT_D     = 7'b1011110;
  localparam logic [6:0] PAT_U     = 7'b0111110;
  localparam logic [6:0] PAT_L     = 7'b0111000;
  localparam logic [6:0] PAT_DASH  = 7'b1000000;
  localparam logic [6:0] PAT_J     = 7'b0001110;
  localparam logic [6:0] PAT_O     = 7'b0111111;
  localparam logic [6:0] PAT_S     = 7'b1101101;
  localparam logic [6:0] PAT_E     = 7'b1111001;

  localparam logic [3:0] CODE_A    = 4'd0;
  localparam logic [3:0] CODE_B    = 4'd1;
  localparam logic [3:0] CODE_D    = 4'd2;
  localparam logic [3:0] CODE_U    = 4'd3;
  localparam logic [3:0] CODE_L    = 4'd4;
  localparam logic [3:0] CODE_DASH = 4'd5;
  localparam logic [3:0] CODE_J    = 4'd6;
  localparam logic [3:0] CODE_O    = 4'd7;
  localparam logic [3:0] CODE_S    = 4'd8;
  localparam logic [3:0] CODE_E    = 4'd9;
  localparam logic [3:0] ERR_CODE  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_reader_if.sv
// Segment sample input plus the 1-deep valid/ready result port of the reader.
// The slave modport is the reader side, and the master modport is the driver/consumer side.
interface seg7_reader_if;
  logic [6:0] seg_in;
  logic       seg_strobe;
  logic [3:0] code_out;
  logic       code_err;
  logic       code_valid;
  logic       code_ready;
  logic       overrun;

  modport slave (
    input  seg_in,
    input  seg_strobe,
    input  code_ready,
    output code_out,
    output code_err,
    output code_valid,
    output overrun
  );

  modport master (
    output seg_in,
    output seg_strobe,
    output code_ready,
    input  code_out,
    input  code_err,
    input  code_valid,
    input  overrun
  );
endinterface

// File: rtl/seg7_lookup.sv
// Combinational pattern-to-letter lookup.
// A pattern that is not in the letter table yields ERR_CODE with err set.
module seg7_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_code,
  output logic       o_err
);

  always_comb begin
    o_code = ERR_CODE;
    o_err  = 1'b1;
    unique case (i_pat)
      PAT_A:    begin o_code = CODE_A;    o_err = 1'b0; end
      PAT_B:    begin o_code = CODE_B;    o_err = 1'b0; end
      PAT_D:    begin o_code = CODE_D;    o_err = 1'b0; end
      PAT_U:    begin o_code = CODE_U;    o_err = 1'b0; end
      PAT_L:    begin o_code = CODE_L;    o_err = 1'b0; end
      PAT_DASH: begin o_code = CODE_DASH; o_err = 1'b0; end
      PAT_J:    begin o_code = CODE_J;    o_err = 1'b0; end
      PAT_O:    begin o_code = CODE_O;    o_err = 1'b0; end
      PAT_S:    begin o_code = CODE_S;    o_err = 1'b0; end
      PAT_E:    begin o_code = CODE_E;    o_err = 1'b0; end
      default:  begin o_code = ERR_CODE;  o_err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Debounces strobed 7-segment samples, so that one result is emitted per stable letter.
// Results go out through a 1-deep valid/ready buffer, and the sticky overrun flag records any dropped result.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE = 3
) (
  input logic        clk,
  input logic        rst,
  seg7_reader_if.slave bus
);

  localparam logic [3:0] STB = 4'(STABLE);

  state_t     r_state;
  state_t     w_state_nx;
  logic [6:0] r_cand;
  logic [6:0] w_cand_nx;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nx;
  logic       w_adv;
  logic       w_push;
  logic [3:0] r_code;
  logic       r_err;
  logic       r_valid;
  logic       r_ovr;
  logic [3:0] w_lk_code;
  logic       w_lk_err;

  seg7_lookup u_lookup (
    .i_pat  (w_cand_nx),
    .o_code (w_lk_code),
    .o_err  (w_lk_err)
  );

  // A new or repeated sample advances the count; reaching STABLE pushes the result once.
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_adv      = 1'b0;
    w_push     = 1'b0;
    if (bus.seg_strobe) begin
      unique case (1'b1)
        (bus.seg_in == PAT_BLANK): begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = 4'd0;
        end
        (r_state != ST_IDLE && bus.seg_in == r_cand): begin
          if (r_state == ST_QUALIFY) begin
            w_cnt_nx = r_cnt + 4'd1;
            w_adv    = 1'b1;
          end
        end
        default: begin
          w_cand_nx = bus.seg_in;
          w_cnt_nx  = 4'd1;
          w_adv     = 1'b1;
        end
      endcase
      if (w_adv) begin
        if (w_cnt_nx == STB) begin
          w_push     = 1'b1;
          w_state_nx = ST_HOLD;
        end else begin
          w_state_nx = ST_QUALIFY;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cand  <= 7'd0;
      r_cnt   <= 4'd0;
      r_code  <= 4'd0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cand  <= w_cand_nx;
      r_cnt   <= w_cnt_nx;
      if (w_push) begin
        if (!r_valid || bus.code_ready) begin
          r_code  <= w_lk_code;
          r_err   <= w_lk_err;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.code_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.code_out   = r_code;
  assign bus.code_err   = r_err;
  assign bus.code_valid = r_valid;
  assign bus.overrun    = r_ovr;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with a latency-aware scoreboard.
// It applies strobe sequences, queues the expected results and checks them at each handshake.
module tb_seg7_reader;
  import seg7_pkg::*;

  typedef struct {
    logic [3:0] code;
    logic       err;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   n = 0;
  exp_t q[$];

  seg7_reader_if bus ();

  seg7_reader #(.STABLE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_push(input logic [3:0] c, input logic e,
                          input bit lat);
    exp_t x;
    x.code = c;
    x.err  = e;
    x.due  = lat ? n + 1 : -1;
    q.push_back(x);
  endtask

  task automatic step(input logic s, input logic [6:0] p,
                      input logic rdy);
    exp_t x;
    @(negedge clk);
    n++;
    bus.seg_strobe = s;
    bus.seg_in     = p;
    bus.code_ready = rdy;
    if (bus.code_valid && bus.code_ready) begin
      chk("spurious", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("code", 32'(bus.code_out), 32'(x.code));
        chk("err", 32'(bus.code_err), 32'(x.err));
        if (x.due >= 0) chk("latency", n, x.due);
      end
    end
  endtask

  initial begin
    bus.seg_strobe = 1'b0;
    bus.seg_in     = 7'd0;
    bus.code_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_code", 32'(bus.code_out), 0);
    chk("rst_err", 32'(bus.code_err), 0);
    chk("rst_valid", 32'(bus.code_valid), 0);
    chk("rst_ovr", 32'(bus.overrun), 0);
    rst = 1'b0;

    step(1, PAT_A, 1);
    step(1, PAT_A, 1);
    step(1, PAT_A, 1);
    exp_push(4'd0, 1'b0, 1);
    repeat (5) step(1, PAT_A, 1);
    step(0, 7'd0, 1);
    step(0, 7'd0, 1);
    chk("a_once_valid", 32'(bus.code_valid), 0);
    step(1, PAT_BLANK, 1);

    step(1, PAT_E, 1);
    step(1, PAT_E, 1);
    step(1, PAT_O, 1);
    step(1, PAT_O, 1);
    step(1, PAT_O, 1);
    exp_push(4'd7, 1'b0, 1);
    step(1, PAT_BLANK, 1);

    step(1, 7'b1010101, 1);
    step(1, 7'b1010101, 1);
    step(1, 7'b1010101, 1);
    exp_push(4'hF, 1'b1, 1);
    step(1, PAT_BLANK, 1);

    step(1, PAT_A, 1);
    step(1, PAT_A, 1);
    step(1, PAT_A, 1);
    exp_push(4'd0, 1'b0, 1);
    step(1, PAT_BLANK, 1);
    step(1, PAT_A, 1);
    step(1, PAT_A, 1);
    step(1, PAT_A, 1);
    exp_push(4'd0, 1'b0, 1);
    step(1, PAT_BLANK, 1);
    step(0, 7'd0, 1);

    step(1, PAT_S, 0);
    step(1, PAT_S, 0);
    step(1, PAT_S, 0);
    exp_push(4'd8, 1'b0, 0);
    step(1, PAT_BLANK, 0);
    step(1, PAT_L, 0);
    step(1, PAT_L, 0);
    step(1, PAT_L, 0);
    step(0, 7'd0, 0);
    chk("ovr_code", 32'(bus.code_out), 8);
    chk("ovr_err", 32'(bus.code_err), 0);
    chk("ovr_valid", 32'(bus.code_valid), 1);
    chk("ovr_flag", 32'(bus.overrun), 1);
    step(0, 7'd0, 1);
    step(0, 7'd0, 1);
    chk("ovr_drop_valid", 32'(bus.code_valid), 0);
    chk("ovr_sticky", 32'(bus.overrun), 1);

    step(1, PAT_B, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_code", 32'(bus.code_out), 0);
    chk("mid_rst_valid", 32'(bus.code_valid), 0);
    chk("mid_rst_ovr", 32'(bus.overrun), 0);
    #1 rst = 1'b0;
    step(1, PAT_B, 1);
    step(1, PAT_B, 1);
    step(0, 7'd0, 1);
    chk("b_fresh_valid", 32'(bus.code_valid), 0);
    step(1, PAT_B, 1);
    exp_push(4'd1, 1'b0, 1);
    step(0, 7'd0, 1);
    step(0, 7'd0, 1);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE, default 3, is the number of consecutive identical strobed samples required to qualify a pattern; legal range 1..15.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 seg_in  input  7  sampled 7-segment pattern, bit order {g,f,e,d,c,b,a}, 1 = lit.
REQ-005 seg_strobe  input  1  sample enable; seg_in is considered only in cycles where this is 1.
REQ-006 code_out  output  4  decoded letter index.
REQ-007 code_err  output  1  held pattern was not in the letter table.
REQ-008 code_valid  output  1  code_out/code_err hold a result.
REQ-009 code_ready  input  1  consumer accepts the result when code_valid && code_ready.
REQ-010 overrun  output  1  sticky flag: a qualified result was dropped.

Function
REQ-011 Letter table (pattern -> code): 1110111->0 A, 1111100->1 B, 1011110->2 D, 0111110->3 U, 0111000->4 L, 1000000->5 '-', 0001110->6 J, 0111111->7 O, 1101101->8 S, 1111001->9 E.
REQ-012 Any non-blank pattern not in the table decodes to code 4'hF with code_err=1; table hits give code_err=0.
REQ-013 Blank (7'b0000000) is never emitted; it returns the FSM to IDLE.
REQ-014 FSM states: IDLE, QUALIFY, HOLD; candidate register cand[6:0]; 4-bit counter cnt.
REQ-015 IDLE: on a strobe with non-blank seg_in, go to QUALIFY with cand=seg_in and cnt=1.
REQ-016 QUALIFY: on a strobe with seg_in==cand, cnt increments; on a strobe with a different non-blank seg_in, cand=seg_in and cnt=1; a blank strobe goes to IDLE.
REQ-017 When cnt reaches STABLE, the decode of cand is pushed in that same edge, and the FSM goes to HOLD; with STABLE=1 the push happens on the first strobe.
REQ-018 HOLD: identical strobes do nothing, so one push is made per stable pattern; a different non-blank strobe goes to QUALIFY with cnt=1; a blank strobe goes to IDLE.
REQ-019 Latency: code_valid rises on the clock edge after the qualifying strobe edge, i.e. registered, 1 cycle.
REQ-020 Output buffer is 1 deep: a push with code_valid=0, or with code_valid && code_ready in the same cycle, loads code_out/code_err and sets code_valid=1.
REQ-021 A push with code_valid=1 and code_ready=0 is dropped, the buffer is unchanged, and overrun is set to 1.
REQ-022 Handshake with no push: code_valid && code_ready clears code_valid next edge; code_out/code_err hold their last values.
REQ-023 code_out/code_err are stable while code_valid=1 && code_ready=0.
REQ-024 seg_strobe=0 cycles freeze cand/cnt/state; the handshake still proceeds.

Reset
REQ-025 rst=1 immediately forces: state IDLE, cand=0, cnt=0, code_out=0, code_err=0, code_valid=0, overrun=0.
REQ-026 Reset mid-QUALIFY or with a pending result discards the candidate and the result; after release, qualification restarts from IDLE.
REQ-027 overrun is cleared only by rst.

Structure
REQ-028 The letter pattern constants (10 x 7 bits), the code constants, ERR_CODE=4'hF, and the FSM state encoding live in the shared seg7 package used by the existing segment decoder.
REQ-029 Pattern-to-code lookup is one combinational sub-module, seg7_lookup (in: 7-bit pattern; out: 4-bit code, err); all sequential logic stays in seg7_reader.

Verification
REQ-030 STABLE=3, code_ready=1, 3 strobes of 1110111 -> one cycle of code_valid with code_out=0, code_err=0; 5 further identical strobes -> no further push.
REQ-031 Strobes 1111001, 1111001, 0111111, 0111111, 0111111 -> single result code_out=7 (O); the E pair is never emitted.
REQ-032 3 strobes of 1010101 -> code_out=4'hF, code_err=1.
REQ-033 code_ready=0, qualify S (8), then blank, then 3 strobes of L -> code_out remains 8, overrun=1; then code_ready=1 -> code_valid drops next edge.
REQ-034 Qualify A, then blank, then A x3 -> two separate pushes of code 0; rst pulsed between strobes 1 and 2 of a B qualification -> all outputs 0, and B needs 3 fresh strobes.
